// File: rtl/mem_stage_ctrl_if.sv
// Data-memory request/acknowledge bus between the MEM-stage controller and data memory.
// The controller is the master; the memory answers with ack and read data.
interface mem_stage_ctrl_if;
   localparam int unsigned DATA_W = 32;

   logic              dmem_req;
   logic              dmem_we;
   logic [DATA_W-1:0] dmem_addr;
   logic [DATA_W-1:0] dmem_wdata;
   logic              dmem_ack;
   logic [DATA_W-1:0] dmem_rdata;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_wdata,
      input  dmem_ack, dmem_rdata
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
      output dmem_ack, dmem_rdata
   );
endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: issues load/store accesses over a req/ack bus, stalls the
// upstream pipeline while an access is outstanding, and fills the MEM/WB register.
module mem_stage_ctrl #(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CNT_W   = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  RegWr_M,
   input  logic                  MemWr_M,
   input  logic                  MemtoReg_M,
   input  logic                  RegDst_M,
   input  logic [4:0]            Rd_M,
   input  logic [4:0]            Rt_M,
   input  logic [31:0]           PC_M,
   input  logic [31:0]           result_M,
   input  logic [31:0]           rt_data_M,
   mem_stage_ctrl_if.master      dmem,
   output logic                  stall_M,
   output logic                  RegWr_W,
   output logic                  MemtoReg_W,
   output logic [4:0]            WriteReg_W,
   output logic [31:0]           result_W,
   output logic [31:0]           read_data_W,
   output logic [31:0]           PC_W,
   output logic                  addr_err,
   output logic                  timeout_err
);

   localparam int unsigned REG_W  = 5;
   localparam int unsigned DATA_W = 32;
   localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TIMEOUT - 1);

   typedef enum logic [0:0] {ST_IDLE, ST_WAIT} state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                req_q, req_d;
   logic                we_q, we_d;
   logic [DATA_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                lat_regwr_q, lat_regwr_d;
   logic                lat_load_q, lat_load_d;
   logic [REG_W-1:0]    lat_wreg_q, lat_wreg_d;
   logic [DATA_W-1:0]   lat_pc_q, lat_pc_d;
   logic                regwr_w_d, memtoreg_w_d;
   logic [REG_W-1:0]    wreg_w_d;
   logic [DATA_W-1:0]   result_w_d, rdata_w_d, pc_w_d;
   logic                addr_err_d, timeout_err_d;
   logic                stall_c;

   logic                mem_op;
   logic                aligned;
   logic [REG_W-1:0]    wreg_sel;

   assign mem_op   = MemWr_M | MemtoReg_M;
   assign aligned  = (result_M[1:0] == 2'b00);
   assign wreg_sel = RegDst_M ? Rd_M : Rt_M;

   // Reset forces the combinational stall low along with every registered output.
   assign stall_M = rst_n & stall_c;

   assign dmem.dmem_req   = req_q;
   assign dmem.dmem_we    = we_q;
   assign dmem.dmem_addr  = addr_q;
   assign dmem.dmem_wdata = wdata_q;

   // Next-state, request and MEM/WB logic
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      req_d         = req_q;
      we_d          = we_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      lat_regwr_d   = lat_regwr_q;
      lat_load_d    = lat_load_q;
      lat_wreg_d    = lat_wreg_q;
      lat_pc_d      = lat_pc_q;
      regwr_w_d     = RegWr_W;
      memtoreg_w_d  = MemtoReg_W;
      wreg_w_d      = WriteReg_W;
      result_w_d    = result_W;
      rdata_w_d     = read_data_W;
      pc_w_d        = PC_W;
      addr_err_d    = 1'b0;
      timeout_err_d = 1'b0;
      stall_c       = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            cnt_d        = '0;
            wreg_w_d     = wreg_sel;
            result_w_d   = result_M;
            pc_w_d       = PC_M;
            rdata_w_d    = '0;
            memtoreg_w_d = 1'b0;
            if (mem_op && aligned) begin
               stall_c     = 1'b1;
               state_d     = ST_WAIT;
               req_d       = 1'b1;
               we_d        = MemWr_M;
               addr_d      = result_M;
               wdata_d     = rt_data_M;
               lat_regwr_d = RegWr_M;
               lat_load_d  = MemtoReg_M & ~MemWr_M;
               lat_wreg_d  = wreg_sel;
               lat_pc_d    = PC_M;
               regwr_w_d   = 1'b0;
            end else if (mem_op) begin
               regwr_w_d  = 1'b0;
               addr_err_d = 1'b1;
            end else begin
               regwr_w_d  = RegWr_M;
            end
         end

         ST_WAIT: begin
            // Ack has priority over the terminal count.
            if (dmem.dmem_ack) begin
               state_d      = ST_IDLE;
               req_d        = 1'b0;
               cnt_d        = '0;
               regwr_w_d    = lat_regwr_q;
               memtoreg_w_d = lat_load_q;
               wreg_w_d     = lat_wreg_q;
               result_w_d   = addr_q;
               pc_w_d       = lat_pc_q;
               rdata_w_d    = lat_load_q ? dmem.dmem_rdata : '0;
            end else if (cnt_q == CNT_TERM) begin
               state_d       = ST_IDLE;
               req_d         = 1'b0;
               cnt_d         = '0;
               regwr_w_d     = 1'b0;
               memtoreg_w_d  = 1'b0;
               timeout_err_d = 1'b1;
            end else begin
               stall_c = 1'b1;
               cnt_d   = cnt_q + 1'b1;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         req_q       <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         lat_regwr_q <= 1'b0;
         lat_load_q  <= 1'b0;
         lat_wreg_q  <= '0;
         lat_pc_q    <= '0;
         RegWr_W     <= 1'b0;
         MemtoReg_W  <= 1'b0;
         WriteReg_W  <= '0;
         result_W    <= '0;
         read_data_W <= '0;
         PC_W        <= '0;
         addr_err    <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         req_q       <= req_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         lat_regwr_q <= lat_regwr_d;
         lat_load_q  <= lat_load_d;
         lat_wreg_q  <= lat_wreg_d;
         lat_pc_q    <= lat_pc_d;
         RegWr_W     <= regwr_w_d;
         MemtoReg_W  <= memtoreg_w_d;
         WriteReg_W  <= wreg_w_d;
         result_W    <= result_w_d;
         read_data_W <= rdata_w_d;
         PC_W        <= pc_w_d;
         addr_err    <= addr_err_d;
         timeout_err <= timeout_err_d;
      end
   end

endmodule
